// File: rtl/reservation_station_q.sv
// Multi-entry ALU reservation station: compacted age queue with CDB wakeup
// and oldest-ready select feeding one ALU.
module reservation_station_q #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load_word,
  input  logic [CTRL_W-1:0] control_word,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              rob_v1,
  input  logic              rob_v2,
  input  logic [TAG_W-1:0]  rob_tag1,
  input  logic [TAG_W-1:0]  rob_tag2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              alu_free,
  output logic              start_exe,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              res_empty,
  output logic              res_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]  val_q, val_d;
  logic [DEPTH-1:0]  rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [TAG_W-1:0]  tag1_q [DEPTH];
  logic [TAG_W-1:0]  tag1_d [DEPTH];
  logic [TAG_W-1:0]  tag2_q [DEPTH];
  logic [TAG_W-1:0]  tag2_d [DEPTH];
  logic [DATA_W-1:0] opa_q  [DEPTH];
  logic [DATA_W-1:0] opa_d  [DEPTH];
  logic [DATA_W-1:0] opb_q  [DEPTH];
  logic [DATA_W-1:0] opb_d  [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DEPTH-1:0]  w_rdy1, w_rdy2;
  logic [DATA_W-1:0] w_opa [DEPTH];
  logic [DATA_W-1:0] w_opb [DEPTH];

  logic          found;
  logic [IW-1:0] sel;
  logic          issue;
  logic          load_ok;
  logic [CW-1:0] ld_idx;
  logic          n_rdy1, n_rdy2;
  logic [DATA_W-1:0] n_opa, n_opb;

  assign res_empty = (cnt_q == '0);
  assign res_full  = (cnt_q == CW'(DEPTH));
  assign load_ok   = load_word && !res_full;

  // Wakeup is computed on the current slots, before any shift.
  always_comb begin
    w_rdy1 = rdy1_q;
    w_rdy2 = rdy2_q;
    w_opa  = opa_q;
    w_opb  = opb_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && !rdy1_q[i] && tag1_q[i] == cdb_tag) begin
        w_rdy1[i] = 1'b1;
        w_opa[i]  = cdb_data;
      end
      if (cdb_valid && !rdy2_q[i] && tag2_q[i] == cdb_tag) begin
        w_rdy2[i] = 1'b1;
        w_opb[i]  = cdb_data;
      end
    end
  end

  // Oldest ready entry wins; uses registered readiness only.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (val_q[i] && rdy1_q[i] && rdy2_q[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign issue     = alu_free && found;
  assign start_exe = issue;
  assign alu_ctrl  = found ? ctrl_q[sel] : '0;
  assign alu_a     = found ? opa_q[sel]  : '0;
  assign alu_b     = found ? opb_q[sel]  : '0;

  assign n_rdy1 = rob_v1 || (cdb_valid && cdb_tag == rob_tag1);
  assign n_rdy2 = rob_v2 || (cdb_valid && cdb_tag == rob_tag2);
  assign n_opa  = rob_v1 ? src1 : cdb_data;
  assign n_opb  = rob_v2 ? src2 : cdb_data;
  assign ld_idx = cnt_q - CW'(issue);

  always_comb begin
    val_d  = val_q;
    rdy1_d = w_rdy1;
    rdy2_d = w_rdy2;
    ctrl_d = ctrl_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    opa_d  = w_opa;
    opb_d  = w_opb;
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) begin
          val_d[i]  = val_q[i+1];
          rdy1_d[i] = w_rdy1[i+1];
          rdy2_d[i] = w_rdy2[i+1];
          ctrl_d[i] = ctrl_q[i+1];
          tag1_d[i] = tag1_q[i+1];
          tag2_d[i] = tag2_q[i+1];
          opa_d[i]  = w_opa[i+1];
          opb_d[i]  = w_opb[i+1];
        end
      end
      val_d[DEPTH-1]  = 1'b0;
      rdy1_d[DEPTH-1] = 1'b0;
      rdy2_d[DEPTH-1] = 1'b0;
    end
    if (load_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_idx == CW'(i)) begin
          val_d[i]  = 1'b1;
          ctrl_d[i] = control_word;
          rdy1_d[i] = n_rdy1;
          rdy2_d[i] = n_rdy2;
          tag1_d[i] = rob_tag1;
          tag2_d[i] = rob_tag2;
          opa_d[i]  = n_opa;
          opb_d[i]  = n_opb;
        end
      end
    end
    cnt_d = cnt_q - CW'(issue) + CW'(load_ok);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      val_q  <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      cnt_q  <= '0;
    end else begin
      val_q  <= val_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload is qualified by the valid/ready bits, so it needs no reset.
  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    tag1_q <= tag1_d;
    tag2_q <= tag2_d;
    opa_q  <= opa_d;
    opb_q  <= opb_d;
  end

endmodule

// File: tb/tb_reservation_station_q.sv
// Directed vector bench for reservation_station_q: per-cycle stimulus rows
// with hand-computed outputs, plus reset and dispatch-latency sequences.
module tb_reservation_station_q;

  logic        clk, rst, flush, load_word;
  logic [47:0] control_word;
  logic [31:0] src1, src2;
  logic        rob_v1, rob_v2;
  logic [2:0]  rob_tag1, rob_tag2;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        alu_free;
  logic        start_exe;
  logic [47:0] alu_ctrl;
  logic [31:0] alu_a, alu_b;
  logic        res_empty, res_full;

  int checks = 0;
  int failures = 0;

  reservation_station_q dut (
    .clk(clk), .rst(rst), .flush(flush),
    .load_word(load_word), .control_word(control_word),
    .src1(src1), .src2(src2),
    .rob_v1(rob_v1), .rob_v2(rob_v2),
    .rob_tag1(rob_tag1), .rob_tag2(rob_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_free(alu_free), .start_exe(start_exe),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .res_empty(res_empty), .res_full(res_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [47:0] ctrl;
    logic [31:0] s1;
    logic        v1;
    logic [2:0]  t1;
    logic [31:0] s2;
    logic        v2;
    logic [2:0]  t2;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    logic        af;
    logic        fl;
    logic        es;
    logic [47:0] ectrl;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eemp;
    logic        efull;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic ld, input logic [47:0] ctrl,
    input logic [31:0] s1, input logic v1, input logic [2:0] t1,
    input logic [31:0] s2, input logic v2, input logic [2:0] t2,
    input logic cv, input logic [2:0] ct, input logic [31:0] cd,
    input logic af, input logic fl,
    input logic es, input logic [47:0] ectrl,
    input logic [31:0] ea, input logic [31:0] eb,
    input logic eemp, input logic efull);
    vec_t v;
    v.ld = ld; v.ctrl = ctrl; v.s1 = s1; v.v1 = v1; v.t1 = t1;
    v.s2 = s2; v.v2 = v2; v.t2 = t2;
    v.cv = cv; v.ct = ct; v.cd = cd; v.af = af; v.fl = fl;
    v.es = es; v.ectrl = ectrl; v.ea = ea; v.eb = eb;
    v.eemp = eemp; v.efull = efull;
    vq.push_back(v);
  endtask

  task automatic idle();
    load_word = 0; control_word = '0; src1 = '0; src2 = '0;
    rob_v1 = 0; rob_v2 = 0; rob_tag1 = '0; rob_tag2 = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    alu_free = 0; flush = 0;
  endtask

  task automatic chk(input string nm, input logic ok, input string det);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s %s", nm, det);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    //  ld ctrl s1     v1 t1 s2 v2 t2  cv ct cd     af fl  es ctrl a      b      emp full
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     0, 0,  0, 0,  0,     0,     1, 0);
    add(1, 1,  0,     0, 1, 3, 1, 0,  0, 0, 0,     0, 0,  0, 0,  0,     0,     1, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     0, 0,  0, 0,  0,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  1, 1, 2,     1, 0,  0, 0,  0,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 1,  2,     3,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(1, 2,  0,     0, 5, 4, 1, 0,  1, 5, 'h11,  1, 0,  0, 0,  0,     0,     1, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 2,  'h11,  4,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(1, 3,  7,     1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 0,  0,     0,     1, 0);
    add(1, 4,  8,     1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 3,  7,     0,     0, 0);
    add(1, 5,  9,     1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 3,  7,     0,     0, 0);
    add(1, 6,  10,    1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 3,  7,     0,     0, 0);
    add(1, 7,  99,    1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 3,  7,     0,     0, 1);
    add(1, 7,  99,    1, 0, 0, 1, 0,  0, 0, 0,     1, 0,  1, 3,  7,     0,     0, 1);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 4,  8,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 5,  9,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 6,  10,    0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(1, 8,  0,     0, 2, 0, 1, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(1, 9,  4,     1, 0, 0, 1, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 9,  4,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  1, 2, 'h22,  1, 0,  0, 0,  0,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 8,  'h22,  0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(1, 10, 0,     0, 6, 1, 1, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(1, 11, 0,     0, 6, 2, 1, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     0, 0);
    add(1, 12, 0,     0, 6, 3, 1, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  1, 6, 'h55,  1, 0,  0, 0,  0,     0,     0, 0);
    add(1, 13, 'h66,  1, 0, 4, 1, 0,  0, 0, 0,     1, 0,  1, 10, 'h55,  1,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 11, 'h55,  2,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 12, 'h55,  3,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 13, 'h66,  4,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(1, 14, 1,     1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 0,  0,     0,     1, 0);
    add(1, 15, 2,     1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 14, 1,     0,     0, 0);
    add(1, 16, 3,     1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 14, 1,     0,     0, 0);
    add(1, 17, 4,     1, 0, 0, 1, 0,  0, 0, 0,     1, 1,  1, 14, 1,     0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);
    add(1, 18, 'h30,  1, 0, 0, 1, 0,  0, 0, 0,     0, 0,  0, 0,  0,     0,     1, 0);
    add(1, 19, 'h31,  1, 0, 0, 0, 3,  0, 0, 0,     0, 0,  0, 18, 'h30,  0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  1, 3, 'h77,  1, 0,  1, 18, 'h30,  0,     0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  1, 19, 'h31,  'h77,  0, 0);
    add(0, 0,  0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0,  0,     0,     1, 0);

    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < vq.size(); i++) begin
      load_word = vq[i].ld; control_word = vq[i].ctrl;
      src1 = vq[i].s1; rob_v1 = vq[i].v1; rob_tag1 = vq[i].t1;
      src2 = vq[i].s2; rob_v2 = vq[i].v2; rob_tag2 = vq[i].t2;
      cdb_valid = vq[i].cv; cdb_tag = vq[i].ct; cdb_data = vq[i].cd;
      alu_free = vq[i].af; flush = vq[i].fl;
      @(negedge clk);
      chk($sformatf("row%0d", i),
          start_exe === vq[i].es && alu_ctrl === vq[i].ectrl &&
          alu_a === vq[i].ea && alu_b === vq[i].eb &&
          res_empty === vq[i].eemp && res_full === vq[i].efull,
          $sformatf("got st=%0b ctrl=%0h a=%0h b=%0h emp=%0b full=%0b want st=%0b ctrl=%0h a=%0h b=%0h emp=%0b full=%0b",
                    start_exe, alu_ctrl, alu_a, alu_b, res_empty, res_full,
                    vq[i].es, vq[i].ectrl, vq[i].ea, vq[i].eb, vq[i].eemp, vq[i].efull));
      @(posedge clk);
      #1;
    end

    // Reset while holding an entry and presenting a load.
    idle();
    load_word = 1; control_word = 48'd20; src1 = 32'h40;
    rob_v1 = 1; rob_v2 = 1;
    @(posedge clk); #1;
    control_word = 48'd21; alu_free = 1; rst = 1;
    @(posedge clk); #1;
    idle(); rst = 0; alu_free = 1;
    @(negedge clk);
    chk("rst_clear", res_empty === 1 && start_exe === 0 && alu_a === 0,
        $sformatf("got emp=%0b st=%0b a=%0h want emp=1 st=0 a=0",
                  res_empty, start_exe, alu_a));

    // Dispatch latency: not selectable in the load cycle, issues the next.
    @(posedge clk); #1;
    load_word = 1; control_word = 48'd22; src1 = 32'h50; src2 = 32'h5;
    rob_v1 = 1; rob_v2 = 1; alu_free = 1;
    @(negedge clk);
    chk("load_cycle", start_exe === 0,
        $sformatf("got st=%0b want st=0", start_exe));
    @(posedge clk); #1;
    idle(); alu_free = 1;
    @(negedge clk);
    chk("next_cycle", start_exe === 1 && alu_a === 32'h50 &&
        alu_b === 32'h5 && alu_ctrl === 48'd22,
        $sformatf("got st=%0b a=%0h b=%0h ctrl=%0h want st=1 a=50 b=5 ctrl=16",
                  start_exe, alu_a, alu_b, alu_ctrl));
    @(posedge clk); #1;
    @(negedge clk);
    chk("drained", res_empty === 1 && start_exe === 0,
        $sformatf("got emp=%0b st=%0b want emp=1 st=0", res_empty, start_exe));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
